reg_write_arbiter: RTL



---
 rtl/reg_write_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - round-robin arbiter sharing the register memory write port
// Define REG_WRITE_ARBITER_LOCK_EN to add req_lock for exclusive multi-beat ownership.
module reg_write_arbiter #(
   parameter  int NUM_REQ    = 3,
   parameter  int ADDR_WIDTH = 8,
   parameter  int DATA_WIDTH = 32,
   localparam int SRC_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
`ifdef REG_WRITE_ARBITER_LOCK_EN
   input  logic [NUM_REQ-1:0]            req_lock,
`endif
   output logic                          mem_valid,
   input  logic                          mem_ready,
   output logic [ADDR_WIDTH-1:0]         mem_addr,
   output logic [DATA_WIDTH-1:0]         mem_wdata,
   output logic [SRC_WIDTH-1:0]          mem_src
);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] ISSUE = 1'b1;

   logic [0:0]           state;
   logic [SRC_WIDTH-1:0] last_grant;
   logic [SRC_WIDTH-1:0] search_base;
   logic [SRC_WIDTH-1:0] rr_grant;
   logic [SRC_WIDTH-1:0] grant;
   logic [SRC_WIDTH-1:0] idx;
   logic                 rr_found;
   logic                 grant_found;
   logic                 accept;

`ifdef REG_WRITE_ARBITER_LOCK_EN
   logic                 locked;
   logic [SRC_WIDTH-1:0] lock_owner;
   logic                 lock_hold;

   // An idle owner drops the lock; the search then resumes just after it.
   assign lock_hold   = locked && req_valid[lock_owner];
   assign search_base = locked ? lock_owner : last_grant;
`else
   assign search_base = last_grant;
`endif

   always_comb begin
      rr_found = 1'b0;
      rr_grant = '0;
      idx      = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = SRC_WIDTH'((int'(search_base) + k) % NUM_REQ);
         if (!rr_found && req_valid[idx]) begin
            rr_found = 1'b1;
            rr_grant = idx;
         end
      end
   end

`ifdef REG_WRITE_ARBITER_LOCK_EN
   assign grant       = lock_hold ? lock_owner : rr_grant;
   assign grant_found = lock_hold | rr_found;
`else
   assign grant       = rr_grant;
   assign grant_found = rr_found;
`endif

   assign accept    = (state == IDLE) && grant_found;
   assign req_ready = (rstn && accept) ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant) : '0;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= IDLE;
         last_grant <= SRC_WIDTH'(NUM_REQ - 1);
         mem_valid  <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_src    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  mem_valid <= 1'b1;
                  mem_addr  <= req_addr[grant*ADDR_WIDTH +: ADDR_WIDTH];
                  mem_wdata <= req_wdata[grant*DATA_WIDTH +: DATA_WIDTH];
                  mem_src   <= grant;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               if (mem_ready) begin
                  mem_valid  <= 1'b0;
                  last_grant <= mem_src;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef REG_WRITE_ARBITER_LOCK_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         locked     <= 1'b0;
         lock_owner <= '0;
      end else if (state == IDLE) begin
         if (accept) begin
            locked     <= req_lock[grant];
            lock_owner <= grant;
         end else begin
            locked     <= 1'b0;
         end
      end
   end
`endif

endmodule
